// File: rtl/uart_mem_bridge.sv
// Debug bridge: parses ping / burst-write / burst-read commands from a UART byte
// stream, owns the memory override bus during a transaction and streams replies back.
module uart_mem_bridge #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LAT     = 1,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mem_override,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int DATA_BYTES = (DATA_W + 7) / 8;
    localparam int AW8        = ADDR_BYTES * 8;
    localparam int DW8        = DATA_BYTES * 8;
    localparam int TW         = $clog2(TIMEOUT_CYC + 1);
    localparam int LW         = $clog2(MEM_LAT + 1);

    localparam logic [7:0]    ADDR_LAST = 8'(ADDR_BYTES - 1);
    localparam logic [7:0]    DATA_LAST = 8'(DATA_BYTES - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(MEM_LAT);
    localparam logic [7:0]    ACK   = 8'h06;
    localparam logic [7:0]    NAK   = 8'h15;
    localparam logic [7:0]    CMD_P = 8'h50;
    localparam logic [7:0]    CMD_W = 8'h57;
    localparam logic [7:0]    CMD_R = 8'h52;

    typedef enum logic [3:0] {
        S_IDLE, S_GET_CNT, S_GET_ADDR, S_GET_DATA, S_WRITE,
        S_RD_REQ, S_RD_WAIT, S_SEND, S_REPLY
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_err;
    logic              w_tout;
    logic              w_tx_hs;
    logic              w_rx_state;
    logic              w_cmd_rw;
    logic              w_override;
    logic [AW8-1:0]    w_addr_full;
    logic [DW8-1:0]    w_wdata_full;
    logic [DW8-1:0]    w_rdata_ext;
    logic [AW8-1:0]    r_addr_sh;
    logic [DW8-1:0]    r_wdata_sh;
    logic [DW8-1:0]    r_rdata;
    logic [7:0]        r_cnt;
    logic [7:0]        r_bcnt;
    logic [7:0]        r_tx_data;
    logic [TW-1:0]     r_tout;
    logic [LW-1:0]     r_lat;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_is_wr;
    logic              r_tx_valid;
    logic              r_err;
    logic              r_override;
    logic              r_rnw;
    logic              r_busy;

    assign w_tx_hs      = r_tx_valid & tx_ready;
    assign w_tout       = (r_tout == TOUT_LAST);
    assign w_rx_state   = (r_state == S_GET_CNT) || (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    assign w_cmd_rw     = (rx_data == CMD_W) || (rx_data == CMD_R);
    assign w_addr_full  = (r_addr_sh << 8) | AW8'(rx_data);
    assign w_wdata_full = (r_wdata_sh << 8) | DW8'(rx_data);
    assign w_rdata_ext  = DW8'(mem_rdata);
    assign w_override   = (w_next inside {S_GET_ADDR, S_GET_DATA, S_WRITE, S_RD_REQ, S_RD_WAIT, S_SEND});

    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign mem_override = r_override;
    assign mem_rnw      = r_rnw;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_wdata_sh[DATA_W-1:0];
    assign busy         = r_busy;
    assign err          = r_err;

    // Next-state decode and error pulse request
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rx_valid) begin
                    w_next = S_IDLE;
                end else if (w_cmd_rw) begin
                    w_next = S_GET_CNT;
                end else begin
                    w_next = S_REPLY;
                    w_err  = (rx_data != CMD_P);
                end
            end
            S_GET_CNT, S_GET_ADDR, S_GET_DATA: begin
                if (rx_valid) begin
                    case (r_state)
                        S_GET_CNT:  w_next = S_GET_ADDR;
                        S_GET_ADDR: w_next = (r_bcnt != ADDR_LAST) ? S_GET_ADDR :
                                             (r_is_wr ? S_GET_DATA : S_RD_REQ);
                        default:    w_next = (r_bcnt == DATA_LAST) ? S_WRITE : S_GET_DATA;
                    endcase
                end else if (w_tout) begin
                    w_next = S_IDLE;
                    w_err  = 1'b1;
                end else begin
                    w_next = r_state;
                end
            end
            S_WRITE: begin
                w_next = (r_cnt == 8'd0) ? S_REPLY : S_GET_DATA;
                w_err  = rx_valid;
            end
            S_RD_REQ: begin
                w_next = S_RD_WAIT;
                w_err  = rx_valid;
            end
            S_RD_WAIT: begin
                w_next = (r_lat == LAT_LAST) ? S_SEND : S_RD_WAIT;
                w_err  = rx_valid;
            end
            S_SEND: begin
                if (w_tx_hs && (r_bcnt == DATA_LAST)) begin
                    w_next = (r_cnt == 8'd0) ? S_IDLE : S_RD_REQ;
                end else begin
                    w_next = S_SEND;
                end
                w_err = rx_valid;
            end
            S_REPLY: begin
                w_next = w_tx_hs ? S_IDLE : S_REPLY;
                w_err  = rx_valid;
            end
            default: begin
                w_next = S_IDLE;
                w_err  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath, byte counters and registered bus/handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_sh  <= '0;
            r_wdata_sh <= '0;
            r_rdata    <= '0;
            r_cnt      <= 8'd0;
            r_bcnt     <= 8'd0;
            r_tx_data  <= 8'd0;
            r_tout     <= '0;
            r_lat      <= '0;
            r_mem_addr <= '0;
            r_is_wr    <= 1'b0;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
            r_override <= 1'b0;
            r_rnw      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_err      <= w_err;
            r_override <= w_override;
            r_rnw      <= (w_next != S_WRITE);
            r_busy     <= (w_next != S_IDLE);
            // Idle timer runs only while waiting for command bytes
            if (w_rx_state && !rx_valid) begin
                r_tout <= r_tout + TW'(1);
            end else begin
                r_tout <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_is_wr <= (rx_data == CMD_W);
                        r_bcnt  <= 8'd0;
                        if (!w_cmd_rw) begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= (rx_data == CMD_P) ? ACK : NAK;
                        end
                    end
                end
                S_GET_CNT: begin
                    if (rx_valid) begin
                        r_cnt <= rx_data;
                    end
                end
                S_GET_ADDR: begin
                    if (rx_valid) begin
                        r_addr_sh <= w_addr_full;
                        if (r_bcnt == ADDR_LAST) begin
                            r_bcnt     <= 8'd0;
                            r_mem_addr <= w_addr_full[ADDR_W-1:0];
                        end else begin
                            r_bcnt <= r_bcnt + 8'd1;
                        end
                    end
                end
                S_GET_DATA: begin
                    if (rx_valid) begin
                        r_wdata_sh <= w_wdata_full;
                        r_bcnt     <= (r_bcnt == DATA_LAST) ? 8'd0 : r_bcnt + 8'd1;
                    end
                end
                S_WRITE: begin
                    r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    if (r_cnt == 8'd0) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= ACK;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RD_REQ: begin
                    r_lat <= LW'(1);
                end
                S_RD_WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_rdata    <= w_rdata_ext << 8;
                        r_tx_data  <= w_rdata_ext[DW8-1 -: 8];
                        r_tx_valid <= 1'b1;
                        r_bcnt     <= 8'd0;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                S_SEND: begin
                    if (w_tx_hs) begin
                        if (r_bcnt == DATA_LAST) begin
                            r_tx_valid <= 1'b0;
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                            if (r_cnt != 8'd0) begin
                                r_cnt <= r_cnt - 8'd1;
                            end
                        end else begin
                            r_tx_data <= r_rdata[DW8-1 -: 8];
                            r_rdata   <= r_rdata << 8;
                            r_bcnt    <= r_bcnt + 8'd1;
                        end
                    end
                end
                S_REPLY: begin
                    if (w_tx_hs) begin
                        r_tx_valid <= 1'b0;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: single-byte command table plus hand-written
// write, read-wrap, back-pressure/overrun, timeout and mid-burst reset sequences.
module tb_uart_mem_bridge;
    localparam int TOUT = 40;

    logic        clk, rst;
    logic [7:0]  rx_data, tx_data;
    logic        rx_valid, tx_valid, tx_ready;
    logic        mem_override, mem_rnw, busy, err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    uart_mem_bridge #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_override(mem_override), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] p1, p2;
    logic [7:0]  tx_q [$];
    logic [15:0] wr_a [$];
    logic [15:0] wr_d [$];
    int          err_cnt = 0;
    int          ovr_cnt = 0;
    logic        pl_en;
    logic [15:0] pl_a, pl_d;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-stage read pipeline gives MEM_LAT = 2
    always @(posedge clk) begin
        p1 <= mem[mem_addr];
        p2 <= p1;
    end
    assign mem_rdata = p2;

    // Bus/handshake monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (pl_en) mem[pl_a] = pl_d;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (err) err_cnt++;
        if (mem_override) ovr_cnt++;
        if (mem_override && !mem_rnw) begin
            mem[mem_addr] = mem_wdata;
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(tx_q.size() >= n), 32'd1);
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_a = a;
        pl_d = d;
        pl_en = 1'b1;
        @(negedge clk); #1;
        pl_en = 1'b0;
    endtask

    function automatic logic [31:0] txb(input int i);
        return (tx_q.size() > i) ? 32'(tx_q[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wra(input int i);
        return (wr_a.size() > i) ? 32'(wr_a[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wrd(input int i);
        return (wr_d.size() > i) ? 32'(wr_d[i]) : 32'hDEAD_BEEF;
    endfunction

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         errs;
    } vec_t;

    vec_t vt[6];
    int tb0, w0, e0, o0, k, bad;
    logic seen;

    initial begin
        vt[0] = '{8'h50, 8'h06, 0};
        vt[1] = '{8'h41, 8'h15, 1};
        vt[2] = '{8'h00, 8'h15, 1};
        vt[3] = '{8'hFF, 8'h15, 1};
        vt[4] = '{8'h06, 8'h15, 1};
        vt[5] = '{8'h50, 8'h06, 0};

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        pl_en = 1'b0; pl_a = 16'h0; pl_d = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_override", 32'(mem_override), 32'd0);
        check("rst_rnw", 32'(mem_rnw), 32'd1);
        check("rst_addr_wdata", {mem_addr, mem_wdata}, 32'h0);
        check("rst_busy_err", {30'd0, busy, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-byte commands
        for (int i = 0; i < 6; i++) begin
            tb0 = tx_q.size(); e0 = err_cnt; o0 = ovr_cnt;
            send_byte(vt[i].rx, 0);
            wait_tx(tb0 + 1, 20, $sformatf("vec%0d_tx_timeout", i));
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_tx", i), txb(tb0), 32'(vt[i].tx));
            check($sformatf("vec%0d_ntx", i), 32'(tx_q.size() - tb0), 32'd1);
            check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vt[i].errs));
            check($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - o0), 32'd0);
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
        end

        // Two-word write burst
        tb0 = tx_q.size(); w0 = wr_a.size(); e0 = err_cnt;
        send_byte(8'h57, 3); send_byte(8'h01, 3); send_byte(8'h12, 3); send_byte(8'h34, 3);
        send_byte(8'hAB, 3); send_byte(8'hCD, 3); send_byte(8'h00, 3); send_byte(8'hEF, 0);
        @(negedge clk);
        check("wr_rnw_after_last", 32'(mem_rnw), 32'd0);
        check("wr_ovr_after_last", 32'(mem_override), 32'd1);
        wait_tx(tb0 + 1, 20, "wr_ack_timeout");
        repeat (3) @(negedge clk);
        check("wr_count", 32'(wr_a.size() - w0), 32'd2);
        check("wr0_addr", wra(w0), 32'h1234);
        check("wr0_data", wrd(w0), 32'hABCD);
        check("wr1_addr", wra(w0 + 1), 32'h1235);
        check("wr1_data", wrd(w0 + 1), 32'h00EF);
        check("wr_ack", txb(tb0), 32'h06);
        check("wr_err", 32'(err_cnt - e0), 32'd0);
        check("wr_busy", {31'd0, busy}, 32'd0);

        // Two-word read wrapping FFFF -> 0000
        preload(16'hFFFF, 16'h1111);
        preload(16'h0000, 16'h2222);
        tb0 = tx_q.size();
        send_byte(8'h52, 3); send_byte(8'h01, 3); send_byte(8'hFF, 3); send_byte(8'hFF, 0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tx_valid && k < 20);
        check("rd_first_tx_cycle", 32'(k), 32'd4);
        wait_tx(tb0 + 4, 60, "rd_tx_timeout");
        repeat (3) @(negedge clk);
        check("rd_b0", txb(tb0), 32'h11);
        check("rd_b1", txb(tb0 + 1), 32'h11);
        check("rd_b2", txb(tb0 + 2), 32'h22);
        check("rd_b3", txb(tb0 + 3), 32'h22);
        check("rd_count", 32'(tx_q.size() - tb0), 32'd4);

        // Back-pressure with an overrun byte injected while sending
        preload(16'h0100, 16'hA5C3);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        tb0 = tx_q.size(); e0 = err_cnt;
        send_byte(8'h52, 3); send_byte(8'h00, 3); send_byte(8'h01, 3); send_byte(8'h00, 0);
        k = 0;
        while (!tx_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp_tx_valid", 32'(tx_valid), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'hA5) bad++;
            if (i == 5) begin rx_data = 8'h50; rx_valid = 1'b1; end
            if (i == 6) rx_valid = 1'b0;
        end
        check("bp_stable", 32'(bad), 32'd0);
        check("bp_overrun_err", 32'(err_cnt - e0), 32'd1);
        check("bp_no_tx", 32'(tx_q.size() - tb0), 32'd0);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_tx(tb0 + 2, 20, "bp_tx_timeout");
        repeat (3) @(negedge clk);
        check("bp_b0", txb(tb0), 32'hA5);
        check("bp_b1", txb(tb0 + 1), 32'hC3);
        check("bp_count", 32'(tx_q.size() - tb0), 32'd2);
        check("bp_idle", {30'd0, tx_valid, busy}, 32'd0);

        // Timeout in the middle of a write header
        tb0 = tx_q.size(); w0 = wr_a.size(); e0 = err_cnt;
        send_byte(8'h57, 3); send_byte(8'h00, 3); send_byte(8'h12, 0);
        k = 0; seen = 1'b0;
        while (!seen && k < TOUT + 20) begin
            @(negedge clk);
            k++;
            seen = err;
        end
        check("tout_err_seen", 32'(seen), 32'd1);
        check("tout_cycle_in_window", 32'(k >= TOUT && k <= TOUT + 1), 32'd1);
        repeat (3) @(negedge clk);
        check("tout_idle", {30'd0, busy, mem_override}, 32'd0);
        check("tout_no_write", 32'(wr_a.size() - w0), 32'd0);
        check("tout_no_reply", 32'(tx_q.size() - tb0), 32'd0);
        check("tout_one_err", 32'(err_cnt - e0), 32'd1);

        // Asynchronous reset during the first WRITE of a 4-word burst
        w0 = wr_a.size();
        send_byte(8'h57, 3); send_byte(8'h03, 3); send_byte(8'h20, 3); send_byte(8'h00, 3);
        send_byte(8'h11, 3); send_byte(8'h22, 0);
        @(negedge clk); #1;
        check("rstw_in_write", 32'(mem_rnw), 32'd0);
        rst = 1'b1;
        #1;
        check("rstw_ovr_rnw", {30'd0, mem_override, mem_rnw}, 32'd1);
        check("rstw_addr_wdata", {mem_addr, mem_wdata}, 32'h0);
        check("rstw_tx_busy_err", {29'd0, tx_valid, busy, err}, 32'd0);
        check("rstw_tx_data", 32'(tx_data), 32'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rstw_write_count", 32'(wr_a.size() - w0), 32'd1);
        check("rstw_write_addr", wra(w0), 32'h2000);
        check("rstw_write_data", wrd(w0), 32'h1122);
        tb0 = tx_q.size();
        send_byte(8'h50, 0);
        wait_tx(tb0 + 1, 20, "rstw_ping_timeout");
        check("rstw_ping", txb(tb0), 32'h06);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
